sprite_locator: RTL
===================

Name: sprite_locator

Overview:
- Pipelined stage directly upstream of the sprite colour mux.
- Each pixel clock it takes the VGA draw coordinate and resolves which on-screen object (if any) covers it, by priority.
- Emits the 5-bit object_id and the 10-bit sprite-ROM address (row/col inside a 32x32 sprite) that the mux consumes.
- Game logic loads object positions into a shadow table; the table is committed to the active table once per frame.

Parameters:
- NUM_OBJ, 8, number of object table entries (1..16); entry 0 has highest priority.
- BG_ID, 5'd31, object_id emitted when no object covers the pixel.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- draw_x  in  10  current pixel column from the VGA controller.
- draw_y  in  10  current pixel row from the VGA controller.
- pix_valid  in  1  draw_x/draw_y valid (display-enable).
- frame_start  in  1  one-cycle pulse at vertical blank; commits shadow table to active table.
- wr_en  in  1  shadow-table write strobe.
- wr_idx  in  clog2(NUM_OBJ)  entry written.
- wr_x  in  10  sprite left edge.
- wr_y  in  10  sprite top edge.
- wr_id  in  5  object_id for this entry.
- wr_vis  in  1  entry visible.
- object_id  out  5  resolved object, to sprite mux.
- addr  out  10  sprite-ROM address {row[4:0], col[4:0]}.
- hit  out  1  1 when an object covers the pixel.
- out_valid  out  1  pix_valid delayed to align with the outputs.

Behaviour:
- Reset (async assert, sync release):
  - Shadow and active tables cleared: vis=0, x=y=0, id=0.
  - Outputs: object_id=BG_ID, addr=0, hit=0, out_valid=0.
  - All pipeline registers cleared.
- Shadow write: on a clock edge with wr_en=1, shadow[wr_idx] <= {wr_x, wr_y, wr_id, wr_vis}.
  - An out-of-range wr_idx (>= NUM_OBJ) is ignored.
- Commit: on a clock edge with frame_start=1, active <= shadow, entry-for-entry.
  - If wr_en and frame_start are high in the same cycle, the commit copies the pre-write shadow contents. The write lands in shadow only and becomes active at the next frame_start.
  - The active table never changes except at commit or reset.
- Pipeline, latency 2 cycles from draw_x/draw_y/pix_valid to the outputs:
  - Stage 1 (registered): for each entry i, compute dx_i = draw_x - x_i and dy_i = draw_y - y_i in 11-bit unsigned arithmetic.
  - Stage 1 also registers match_i = vis_i & pix_valid & (draw_x >= x_i) & ({1'b0,draw_x} < x_i+32) & (draw_y >= y_i) & ({1'b0,draw_y} < y_i+32). Bounds use 11 bits, so an edge at x=1000 covers 1000..1023 with no wrap to column 0.
  - Stage 1 keeps dx_i[4:0] and dy_i[4:0].
  - Stage 2 (registered): priority-encode the lowest i with match_i=1.
    - On a hit: object_id=id_i, addr={dy_i[4:0], dx_i[4:0]}, hit=1.
    - With no match: object_id=BG_ID, addr=0, hit=0.
  - out_valid = pix_valid delayed 2 cycles.
  - When pix_valid=0, all matches are forced to 0, so the output is BG_ID/hit=0.
- Overlap: the lowest index wins, regardless of wr_id values.
- Commit mid-pipeline: pixels already in stage 2 keep their old-table result. Pixels sampled on the cycle after the commit edge use the new table.
- Reset asserted mid-frame: the pipeline flushes immediately, and tables are empty until rewritten and committed.

Optional Feature:
- Macro: SPRITE_HFLIP_EN.
- Defined:
  - Adds input port wr_flip (1 bit) and a flip bit per shadow/active entry, written and committed like the other fields.
  - For a hit on a flipped entry, the column is 31 - dx[4:0], so addr={dy[4:0], 5'd31-dx[4:0]}. Reset clears flip.
- Undefined: no wr_flip port, no storage, and the column is always dx[4:0].

Test Plan:
- Reset hold -> object_id=31, addr=0, hit=0, out_valid=0; after release with an empty table, any pixel yields BG_ID with hit=0.
- Write entry 0 {x=100,y=50,id=1,vis=1}, pulse frame_start, drive (131,81) -> after 2 cycles object_id=1, addr=10'h3FF, hit=1. Drive (132,81) -> BG_ID, hit=0.
- Entries 0 {x=10,y=10,id=1} and 3 {x=20,y=20,id=0}, both visible, drive (25,25) -> object_id=1, addr={5'd15,5'd15}. Set entry 0 vis=0, commit, same pixel -> object_id=0, addr={5'd5,5'd5}.
- Write entry 0 x=200 without frame_start, then drive a pixel inside the old position -> still hits at the old position. Assert wr_en and frame_start in the same cycle -> the new value appears only after the second frame_start.
- Entry {x=1000,y=0,vis=1}, drive (5,0) -> hit=0 (no wrap). Drive (1023,0) -> hit=1, addr=10'd23. Any pixel with pix_valid=0 -> hit=0, out_valid=0 two cycles later.
- With SPRITE_HFLIP_EN, entry {x=0,y=0,flip=1}, pixel (2,3) -> addr={5'd3,5'd29}. Assert reset_n low mid-stream -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sprite_locator.sv
// Sprite locator: resolves the highest-priority object under the draw pixel.
// Optional SPRITE_HFLIP_EN adds a per-entry horizontal flip bit.
module sprite_locator #(
  parameter int NUM_OBJ = 8,
  parameter logic [4:0] BG_ID = 5'd31,
  parameter int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic          clk50,
  input  logic          reset_n,
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  input  logic          pix_valid,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [9:0]    wr_x,
  input  logic [9:0]    wr_y,
  input  logic [4:0]    wr_id,
  input  logic          wr_vis,
`ifdef SPRITE_HFLIP_EN
  input  logic          wr_flip,
`endif
  output logic [4:0]    object_id,
  output logic [9:0]    addr,
  output logic          hit,
  output logic          out_valid
);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] id;
    logic       vis;
`ifdef SPRITE_HFLIP_EN
    logic       flip;
`endif
  } ent_t;

  ent_t shd_q [NUM_OBJ];
  ent_t act_q [NUM_OBJ];
  ent_t wr_ent;

  always_comb begin
    wr_ent = '0;
    wr_ent.x = wr_x;
    wr_ent.y = wr_y;
    wr_ent.id = wr_id;
    wr_ent.vis = wr_vis;
`ifdef SPRITE_HFLIP_EN
    wr_ent.flip = wr_flip;
`endif
  end

  // Commit copies pre-write shadow, since both sides use the old value.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_OBJ; i++)
          act_q[i] <= shd_q[i];
      end
      if (wr_en && (32'(wr_idx) < NUM_OBJ))
        shd_q[wr_idx] <= wr_ent;
    end
  end

  logic [NUM_OBJ-1:0] m_d, m_q;
  logic [4:0] col_d [NUM_OBJ];
  logic [4:0] row_d [NUM_OBJ];
  logic [9:0] ad_q [NUM_OBJ];
  logic [4:0] id_q [NUM_OBJ];
  logic       pv1_q;
  logic [10:0] px, py;

  assign px = {1'b0, draw_x};
  assign py = {1'b0, draw_y};

  always_comb begin
    m_d = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_d[i] = act_q[i].vis & pix_valid
             & (px >= {1'b0, act_q[i].x})
             & (px < ({1'b0, act_q[i].x} + 11'd32))
             & (py >= {1'b0, act_q[i].y})
             & (py < ({1'b0, act_q[i].y} + 11'd32));
      col_d[i] = draw_x[4:0] - act_q[i].x[4:0];
      row_d[i] = draw_y[4:0] - act_q[i].y[4:0];
`ifdef SPRITE_HFLIP_EN
      if (act_q[i].flip)
        col_d[i] = ~col_d[i];
`endif
    end
  end

  // Id travels with the pixel so a later commit cannot alter it.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      pv1_q <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        ad_q[i] <= '0;
        id_q[i] <= '0;
      end
    end else begin
      m_q <= m_d;
      pv1_q <= pix_valid;
      for (int i = 0; i < NUM_OBJ; i++) begin
        ad_q[i] <= {row_d[i], col_d[i]};
        id_q[i] <= act_q[i].id;
      end
    end
  end

  logic [4:0] obj_d, obj_q;
  logic [9:0] addr_d, addr_q;
  logic       hit_d, hit_q, ov_q;

  always_comb begin
    obj_d = BG_ID;
    addr_d = '0;
    hit_d = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (m_q[i]) begin
        obj_d = id_q[i];
        addr_d = ad_q[i];
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      obj_q <= BG_ID;
      addr_q <= '0;
      hit_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      obj_q <= obj_d;
      addr_q <= addr_d;
      hit_q <= hit_d;
      ov_q <= pv1_q;
    end
  end

  assign object_id = obj_q;
  assign addr = addr_q;
  assign hit = hit_q;
  assign out_valid = ov_q;

endmodule
